// File: rtl/tic_sat_pkg.sv
// Shared types and constants for the systolic-array output deskew FIFO sequencer.
package tic_sat_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      DRAIN,
      STEP,
      DONE
   } state_e;

   localparam logic [1:0] CMD_HOLD  = 2'b00;
   localparam logic [1:0] CMD_SHIFT = 2'b10;
   localparam logic [1:0] COL_SHIFT = 2'd3;

   localparam int SA_SIZE_DEF       = 16;
   localparam int WORDS_PER_VEC_DEF = 4;

endpackage

// File: rtl/fifo_out_ctrl.sv
// Output deskew FIFO sequencer: fills the skewed FIFO, then drains each aligned vector as 32-bit words.
// Optional stall counter built only when FIFO_OUT_CTRL_PERF_EN is defined.
module fifo_out_ctrl
   import tic_sat_pkg::*;
#(
   parameter int SA_SIZE       = SA_SIZE_DEF,
   parameter int WORDS_PER_VEC = WORDS_PER_VEC_DEF,
   parameter int VEC_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [VEC_W-1:0] num_vec,
   input  logic             sa_valid,
   output logic             sa_ready,
   output logic [1:0]       fifo_command,
   output logic [1:0]       fifo_col,
   input  logic [31:0]      fifo_data,
   output logic [31:0]      m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic             done,
   output logic [15:0]      perf_stall_cnt
);

   localparam int FCW = $clog2(SA_SIZE + 1);
   localparam logic [1:0] WI_LAST = 2'(WORDS_PER_VEC - 1);

   state_e           state_q, state_d;
   logic [FCW-1:0]   fill_cnt_q, fill_cnt_d;
   logic [1:0]       word_idx_q, word_idx_d;
   logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [VEC_W-1:0] num_vec_q, num_vec_d;
   logic             shift;
   logic             start_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fill_cnt_q <= '0;
         word_idx_q <= '0;
         vec_cnt_q  <= '0;
         num_vec_q  <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         word_idx_q <= word_idx_d;
         vec_cnt_q  <= vec_cnt_d;
         num_vec_q  <= num_vec_d;
      end
   end

   assign start_acc = (state_q == IDLE) && start;

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      word_idx_d = word_idx_q;
      vec_cnt_d  = vec_cnt_q;
      num_vec_d  = num_vec_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               fill_cnt_d = '0;
               word_idx_d = '0;
               vec_cnt_d  = '0;
               num_vec_d  = num_vec;
               state_d    = (num_vec != '0) ? FILL : DONE;
            end
         end
         FILL: begin
            if (shift) begin
               fill_cnt_d = fill_cnt_q + FCW'(1);
               if (fill_cnt_q == FCW'(SA_SIZE - 1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (m_ready) begin
               if (word_idx_q == WI_LAST) begin
                  word_idx_d = '0;
                  vec_cnt_d  = vec_cnt_q + VEC_W'(1);
                  state_d    = (vec_cnt_d == num_vec_q) ? DONE : STEP;
               end else begin
                  word_idx_d = word_idx_q + 2'd1;
               end
            end
         end
         // one beat realigns the next vector onto output0
         STEP: begin
            if (shift) state_d = DRAIN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sa_ready = 1'b0;
      m_valid  = 1'b0;
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      case (state_q)
         FILL, STEP: sa_ready = 1'b1;
         DRAIN:      m_valid  = 1'b1;
         default: ;
      endcase
   end

   assign shift        = sa_valid & sa_ready;
   assign fifo_command = shift ? CMD_SHIFT : CMD_HOLD;
   assign fifo_col     = shift ? COL_SHIFT : word_idx_q;
   assign m_data       = fifo_data;

`ifdef FIFO_OUT_CTRL_PERF_EN
   logic [15:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (start_acc)
         perf_d = '0;
      else if (m_valid && !m_ready && (perf_q != 16'hFFFF))
         perf_d = perf_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) perf_q <= '0;
      else       perf_q <= perf_d;
   end

   assign perf_stall_cnt = perf_q;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_out_ctrl.sv
// Directed bench for fifo_out_ctrl; models the FIFO output as {shift count, col}.
module tb_fifo_out_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  num_vec;
   logic        sa_valid;
   logic        sa_ready;
   logic [1:0]  fifo_command;
   logic [1:0]  fifo_col;
   logic [31:0] fifo_data;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        busy;
   logic        done;
   logic [15:0] perf_stall_cnt;

   int checks = 0;
   int errors = 0;

   fifo_out_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
      .sa_valid(sa_valid), .sa_ready(sa_ready),
      .fifo_command(fifo_command), .fifo_col(fifo_col), .fifo_data(fifo_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clk = ~clk;

   // FIFO stand-in: output0 tags the number of shifts seen and the selected column
   logic [29:0] fifo_gen = '0;
   always @(posedge clk) if (fifo_command == 2'b10) fifo_gen <= fifo_gen + 30'd1;
   assign fifo_data = {fifo_gen, fifo_col};

`ifdef FIFO_OUT_CTRL_PERF_EN
   localparam logic [15:0] PERF_BP = 16'd5;
`else
   localparam logic [15:0] PERF_BP = 16'd0;
`endif

   // job observations
   string       r_trace;
   int          r_shifts, r_rdy, r_words, r_word_err, r_shift_col_err;
   int          r_stall_cycles, r_stall_err, r_done_cnt, r_done_cyc, r_first_mv;
   bit          r_timeout, r_aborted;
   logic        r_post_busy;
   logic [15:0] r_perf;

   task tick();
      @(posedge clk);
      #1;
   endtask

   task run_job(input logic [7:0] nv, input int sv_mode, input int stall_word,
                input int stall_len, input bit start_in_drain, input int rst_word);
      logic [29:0] gen0;
      logic [31:0] exp_w;
      int          stall_left;
      bit          fin;
      r_trace = ""; r_shifts = 0; r_rdy = 0; r_words = 0; r_word_err = 0;
      r_shift_col_err = 0; r_stall_cycles = 0; r_stall_err = 0; r_done_cnt = 0;
      r_done_cyc = -1; r_first_mv = -1; r_timeout = 1'b0; r_aborted = 1'b0;
      r_perf = '0; stall_left = stall_len; fin = 1'b0;
      tick();
      gen0 = fifo_gen;
      start = 1'b1; num_vec = nv; sa_valid = 1'b0; m_ready = 1'b1;
      for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
         tick();
         start    = 1'b0;
         sa_valid = (sv_mode == 0) ? 1'b1 : (cyc % 2 == 0);
         m_ready  = 1'b1;
         if (m_valid && r_words == stall_word && stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
         end
         if (start_in_drain && m_valid && r_first_mv < 0) begin
            start = 1'b1; num_vec = 8'd5;
         end
         if (rst_word >= 0 && m_valid && r_words == rst_word) begin
            reset = 1'b1;
            tick();
            reset = 1'b0; start = 1'b0;
            r_aborted = 1'b1;
            fin = 1'b1;
         end else begin
            #1;
            if (sa_ready) begin r_trace = {r_trace, "R"}; r_rdy++; end
            else if (m_valid) r_trace = {r_trace, "V"};
            else if (done) r_trace = {r_trace, "D"};
            else r_trace = {r_trace, "."};
            if (fifo_command == 2'b10) begin
               r_shifts++;
               if (fifo_col !== 2'd3) r_shift_col_err++;
            end
            if (m_valid) begin
               if (r_first_mv < 0) r_first_mv = cyc;
               exp_w = {gen0 + 30'd16 + 30'(r_words / 4), 2'(r_words % 4)};
               if (m_ready) begin
                  if (m_data !== exp_w || fifo_col !== 2'(r_words % 4)) r_word_err++;
                  r_words++;
               end else begin
                  r_stall_cycles++;
                  if (m_data !== exp_w || fifo_col !== 2'(r_words % 4) || fifo_command !== 2'b00)
                     r_stall_err++;
               end
            end
            if (done) begin
               r_done_cnt++;
               r_done_cyc = cyc;
               r_perf = perf_stall_cnt;
               fin = 1'b1;
            end
         end
         if (cyc == 400 && !fin) r_timeout = 1'b1;
      end
      tick();
      r_post_busy = busy;
      if (done) r_done_cnt++;
   endtask

   task test_reset();
      reset = 1'b1; start = 1'b1; num_vec = 8'd3; sa_valid = 1'b1; m_ready = 1'b1;
      tick(); tick();
      checks++;
      if ({sa_ready, m_valid, busy, done, fifo_command, fifo_col, perf_stall_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b mv=%b busy=%b done=%b cmd=%b col=%0d perf=%0d want all 0",
                  sa_ready, m_valid, busy, done, fifo_command, fifo_col, perf_stall_cnt);
      end
      reset = 1'b0; start = 1'b0; sa_valid = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_wins_start busy=%b want 0", busy);
      end
   endtask

   task test_basic();
      run_job(8'd1, 0, -1, 0, 1'b0, -1);
      checks++;
      if (r_timeout || r_shifts != 16 || r_rdy != 16) begin
         errors++; $display("FAIL basic_shifts shifts=%0d rdy=%0d to=%0d want 16 16 0", r_shifts, r_rdy, r_timeout);
      end
      checks++;
      if (r_shift_col_err != 0) begin
         errors++; $display("FAIL basic_shift_col bad=%0d want 0", r_shift_col_err);
      end
      checks++;
      if (r_words != 4 || r_word_err != 0) begin
         errors++; $display("FAIL basic_words words=%0d bad=%0d want 4 0", r_words, r_word_err);
      end
      checks++;
      if (r_first_mv != 17 || r_done_cyc != 21) begin
         errors++; $display("FAIL basic_latency first_mv=%0d done=%0d want 17 21", r_first_mv, r_done_cyc);
      end
      checks++;
      if (r_done_cnt != 1 || r_post_busy !== 1'b0) begin
         errors++; $display("FAIL basic_done done_cnt=%0d busy_after=%b want 1 0", r_done_cnt, r_post_busy);
      end
   endtask

   task test_multi_vector();
      string exp_t;
      exp_t = {"RRRRRRRRRRRRRRRR", "VVVV", "R", "VVVV", "R", "VVVV", "D"};
      run_job(8'd3, 0, -1, 0, 1'b0, -1);
      checks++;
      if (r_trace != exp_t) begin
         errors++; $display("FAIL multi_order got %s want %s", r_trace, exp_t);
      end
      checks++;
      if (r_shifts != 18 || r_words != 12 || r_word_err != 0 || r_shift_col_err != 0) begin
         errors++; $display("FAIL multi_counts shifts=%0d words=%0d bad=%0d colbad=%0d want 18 12 0 0",
                            r_shifts, r_words, r_word_err, r_shift_col_err);
      end
   endtask

   task test_backpressure();
      string exp_t;
      exp_t = {"RRRRRRRRRRRRRRRR", "VVVVVVVVV", "D"};
      run_job(8'd1, 0, 2, 5, 1'b0, -1);
      checks++;
      if (r_stall_cycles != 5 || r_stall_err != 0) begin
         errors++; $display("FAIL bp_stable stalls=%0d bad=%0d want 5 0", r_stall_cycles, r_stall_err);
      end
      checks++;
      if (r_trace != exp_t || r_shifts != 16 || r_words != 4 || r_word_err != 0) begin
         errors++; $display("FAIL bp_flow trace=%s shifts=%0d words=%0d bad=%0d want %s 16 4 0",
                            r_trace, r_shifts, r_words, r_word_err, exp_t);
      end
      checks++;
      if (r_perf !== PERF_BP) begin
         errors++; $display("FAIL bp_perf got %0d want %0d", r_perf, PERF_BP);
      end
   endtask

   task test_upstream_stall();
      run_job(8'd1, 1, -1, 0, 1'b0, -1);
      checks++;
      if (r_shifts != 16 || r_rdy != 32 || r_first_mv != 33) begin
         errors++; $display("FAIL up_stall shifts=%0d rdy=%0d first_mv=%0d want 16 32 33", r_shifts, r_rdy, r_first_mv);
      end
      checks++;
      if (r_words != 4 || r_word_err != 0 || r_done_cnt != 1) begin
         errors++; $display("FAIL up_stall_words words=%0d bad=%0d done=%0d want 4 0 1", r_words, r_word_err, r_done_cnt);
      end
   endtask

   task test_zero_and_ignored_start();
      string exp_t;
      run_job(8'd0, 0, -1, 0, 1'b0, -1);
      checks++;
      if (r_trace != "D" || r_shifts != 0 || r_done_cyc != 1 || r_done_cnt != 1) begin
         errors++; $display("FAIL zero_len trace=%s shifts=%0d done_cyc=%0d done_cnt=%0d want D 0 1 1",
                            r_trace, r_shifts, r_done_cyc, r_done_cnt);
      end
      exp_t = {"RRRRRRRRRRRRRRRR", "VVVV", "R", "VVVV", "D"};
      run_job(8'd2, 0, -1, 0, 1'b1, -1);
      checks++;
      if (r_trace != exp_t || r_words != 8 || r_word_err != 0) begin
         errors++; $display("FAIL ignored_start trace=%s words=%0d bad=%0d want %s 8 0",
                            r_trace, r_words, r_word_err, exp_t);
      end
   endtask

   task test_mid_reset();
      run_job(8'd2, 0, -1, 0, 1'b0, 1);
      checks++;
      if (!r_aborted || busy !== 1'b0 || m_valid !== 1'b0 || sa_ready !== 1'b0 || fifo_command !== 2'b00) begin
         errors++; $display("FAIL mid_reset aborted=%0d busy=%b mv=%b rdy=%b cmd=%b want 1 0 0 0 00",
                            r_aborted, busy, m_valid, sa_ready, fifo_command);
      end
      run_job(8'd1, 0, -1, 0, 1'b0, -1);
      checks++;
      if (r_shifts != 16 || r_first_mv != 17 || r_words != 4 || r_word_err != 0) begin
         errors++; $display("FAIL post_reset_job shifts=%0d first_mv=%0d words=%0d bad=%0d want 16 17 4 0",
                            r_shifts, r_first_mv, r_words, r_word_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi_vector();
      test_backpressure();
      test_upstream_stall();
      test_zero_and_ignored_start();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
